// File: rtl/pipe_perf_monitor.sv
// Windowed performance monitor: cycles/retired/mispredict/flush counters with a coherent 64-bit readout.
// Optional macro PERF_PC_FILTER_EN restricts the retired count to an inclusive PC range.
module pipe_perf_monitor #(
  parameter int CNT_W = 64,
  parameter int WIN_W = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_insn_vld,
  input  logic             i_mispred,
  input  logic             i_ctrl,
  input  logic [31:0]      i_pc,
`ifdef PERF_PC_FILTER_EN
  input  logic [31:0]      i_pc_lo,
  input  logic [31:0]      i_pc_hi,
`endif
  input  logic             i_start,
  input  logic             i_stop,
  input  logic             i_clear,
  input  logic [WIN_W-1:0] i_win_len,
  input  logic [2:0]       i_rd_sel,
  output logic [31:0]      o_rd_data,
  output logic [1:0]       o_state,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_overflow
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  state_t           state_reg, state_next;
  logic [WIN_W-1:0] win_rem_reg;
  logic             win_en_reg;
  logic [31:0]      shadow_reg;
  logic [31:0]      rd_data_reg;
  logic             overflow_reg;

  logic             retire_hit;
  logic             restart;
  logic             counting;
  logic             win_expire;
  logic [3:0]       cnt_inc;
  logic [3:0]       cnt_sat;
  logic [3:0]       cnt_blocked;
  logic [63:0]      cnt64 [4];
  logic [63:0]      sel_cnt;
  logic [31:0]      rd_word;

`ifdef PERF_PC_FILTER_EN
  assign retire_hit = i_insn_vld && (i_pc >= i_pc_lo) && (i_pc <= i_pc_hi);
`else
  logic unused_pc;
  assign unused_pc  = ^i_pc;
  assign retire_hit = i_insn_vld;
`endif

  // Start only acts outside RUN, and clear overrides everything.
  assign restart    = !i_clear && i_start && (state_reg != ST_RUN);
  assign counting   = !i_clear && (state_reg == ST_RUN);
  assign win_expire = win_en_reg && (win_rem_reg == WIN_W'(1));

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (i_clear) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: if (i_start) state_next = ST_RUN;
        ST_RUN:  if (i_stop || win_expire) state_next = ST_DONE;
        ST_DONE: if (i_start) state_next = ST_RUN;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    o_state = state_reg;
    o_busy  = (state_reg == ST_RUN);
    o_done  = (state_reg == ST_DONE);
  end

  // Counter order matches the readout map: cycles, retired, mispred, flush.
  assign cnt_inc = {i_ctrl, i_mispred, retire_hit, 1'b1};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_reg;

      assign cnt_sat[gi]     = &cnt_reg;
      assign cnt_blocked[gi] = counting && cnt_inc[gi] && cnt_sat[gi];
      assign cnt64[gi]       = 64'(cnt_reg);

      always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
          cnt_reg <= '0;
        end else if (i_clear || restart) begin
          cnt_reg <= '0;
        end else if (counting && cnt_inc[gi] && !cnt_sat[gi]) begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      win_rem_reg <= '0;
      win_en_reg  <= 1'b0;
    end else if (i_clear) begin
      win_rem_reg <= '0;
      win_en_reg  <= 1'b0;
    end else if (restart) begin
      win_rem_reg <= i_win_len;
      win_en_reg  <= |i_win_len;
    end else if (counting && win_en_reg && (win_rem_reg != '0)) begin
      win_rem_reg <= win_rem_reg - 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      overflow_reg <= 1'b0;
    end else if (i_clear || restart) begin
      overflow_reg <= 1'b0;
    end else if (|cnt_blocked) begin
      overflow_reg <= 1'b1;
    end
  end

  // Odd selects return the high word captured by the preceding even read.
  assign sel_cnt = cnt64[i_rd_sel[2:1]];

  always_comb begin
    rd_word = shadow_reg;
    if (!i_rd_sel[0]) begin
      rd_word = sel_cnt[31:0];
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      rd_data_reg <= '0;
      shadow_reg  <= '0;
    end else begin
      rd_data_reg <= rd_word;
      if (!i_rd_sel[0]) begin
        shadow_reg <= sel_cnt[63:32];
      end
    end
  end

  assign o_rd_data  = rd_data_reg;
  assign o_overflow = overflow_reg;

endmodule

// File: tb/tb_pipe_perf_monitor.sv
// Scoreboard bench for pipe_perf_monitor: directed scenarios plus random traffic against a behavioural model.
// Honours PERF_PC_FILTER_EN when the design is built with it.
module tb_pipe_perf_monitor;

  localparam int CNT_W = 8;
  localparam int WIN_W = 32;
  localparam logic [63:0] CMAX = (CNT_W == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << CNT_W) - 64'd1);

  logic             i_clk = 1'b0;
  logic             i_reset;
  logic             i_insn_vld, i_mispred, i_ctrl;
  logic [31:0]      i_pc, i_pc_lo, i_pc_hi;
  logic             i_start, i_stop, i_clear;
  logic [WIN_W-1:0] i_win_len;
  logic [2:0]       i_rd_sel;
  logic [31:0]      o_rd_data;
  logic [1:0]       o_state;
  logic             o_busy, o_done, o_overflow;

  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  pipe_perf_monitor #(.CNT_W(CNT_W), .WIN_W(WIN_W)) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_insn_vld (i_insn_vld),
    .i_mispred  (i_mispred),
    .i_ctrl     (i_ctrl),
    .i_pc       (i_pc),
`ifdef PERF_PC_FILTER_EN
    .i_pc_lo    (i_pc_lo),
    .i_pc_hi    (i_pc_hi),
`endif
    .i_start    (i_start),
    .i_stop     (i_stop),
    .i_clear    (i_clear),
    .i_win_len  (i_win_len),
    .i_rd_sel   (i_rd_sel),
    .o_rd_data  (o_rd_data),
    .o_state    (o_state),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_overflow (o_overflow)
  );

  // Behavioural model: measurement state, plain counts, elapsed cycles vs. requested window.
  typedef struct {
    logic [2:0]  sel;
    logic [31:0] data;
  } rd_exp_t;

  rd_exp_t     exp_q[$];
  int          m_state;
  logic [63:0] m_cnt [4];
  bit          m_ovf;
  logic [63:0] m_win_len;
  logic [63:0] m_elapsed;
  logic [31:0] m_shadow;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_state   = 0;
    m_ovf     = 1'b0;
    m_win_len = '0;
    m_elapsed = '0;
    m_shadow  = '0;
    for (int k = 0; k < 4; k++) m_cnt[k] = '0;
  endtask

  task automatic model_step();
    logic [63:0] v;
    rd_exp_t     e;
    bit [3:0]    inc;
    bit          hit;
    v     = m_cnt[int'(i_rd_sel[2:1])];
    e.sel = i_rd_sel;
    if (i_rd_sel[0]) begin
      e.data = m_shadow;
    end else begin
      e.data   = v[31:0];
      m_shadow = v[63:32];
    end
    exp_q.push_back(e);
    hit = i_insn_vld;
`ifdef PERF_PC_FILTER_EN
    hit = i_insn_vld && (i_pc >= i_pc_lo) && (i_pc <= i_pc_hi);
`endif
    inc = {i_ctrl, i_mispred, hit, 1'b1};
    if (i_clear) begin
      m_state = 0;
      m_ovf   = 1'b0;
      for (int k = 0; k < 4; k++) m_cnt[k] = '0;
    end else if (i_start && m_state != 1) begin
      for (int k = 0; k < 4; k++) m_cnt[k] = '0;
      m_ovf     = 1'b0;
      m_win_len = 64'(i_win_len);
      m_elapsed = '0;
      m_state   = 1;
    end else if (m_state == 1) begin
      m_elapsed = m_elapsed + 1;
      for (int k = 0; k < 4; k++) begin
        if (inc[k]) begin
          if (m_cnt[k] >= CMAX) m_ovf = 1'b1;
          else m_cnt[k] = m_cnt[k] + 1;
        end
      end
      if (i_stop) m_state = 2;
      else if (m_win_len != 0 && m_elapsed == m_win_len) m_state = 2;
    end
  endtask

  always @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      model_reset();
      exp_q.delete();
    end else begin
      model_step();
    end
  end

  // Monitor: status every cycle, readout popped from the scoreboard one cycle after the request.
  always @(negedge i_clk) begin
    rd_exp_t e;
    check("state", 64'(o_state), 64'(m_state));
    check("busy", 64'(o_busy), 64'(m_state == 1));
    check("done", 64'(o_done), 64'(m_state == 2));
    check("overflow", 64'(o_overflow), 64'(m_ovf));
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("rd_data", 64'(o_rd_data), 64'(e.data));
      $display("RD sel=%0d data=%08h exp=%08h", e.sel, o_rd_data, e.data);
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic read_word(input logic [2:0] sel, output logic [31:0] data);
    i_rd_sel = sel;
    tick();
    data = o_rd_data;
  endtask

  task automatic wait_done(input int limit, output int n);
    n = 0;
    while (o_state != 2'b10 && n < limit) begin
      tick();
      n++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int          n;
    int          ovf_first;
    logic [31:0] pcs [5];

    model_reset();
    i_reset = 1'b0; i_insn_vld = 0; i_mispred = 0; i_ctrl = 0; i_pc = '0;
    i_pc_lo = 32'h100; i_pc_hi = 32'h10C;
    i_start = 0; i_stop = 0; i_clear = 0; i_win_len = '0; i_rd_sel = '0;
    repeat (3) @(posedge i_clk);
    #1;
    check("reset_state", 64'(o_state), 64'd0);
    check("reset_rd", 64'(o_rd_data), 64'd0);
    i_reset = 1'b1;
    tick(); tick();

    // Fixed window of 10 with retire held high.
    i_win_len = 10; i_insn_vld = 1; i_start = 1;
    tick();
    i_start = 0;
    wait_done(30, n);
    i_insn_vld = 0;
    check("win_len_cycles", 64'(n), 64'd10);
    read_word(3'd0, d); check("win_cyc_lo", 64'(d), 64'h0000000A);
    read_word(3'd1, d); check("win_cyc_hi", 64'(d), 64'h00000000);
    read_word(3'd2, d); check("win_ret_lo", 64'(d), 64'd10);
    $display("TXN fixed_window cycles_to_done=%0d", n);

    // Free-run with explicit stop.
    i_win_len = 0; i_start = 1;
    tick();
    i_start = 0;
    for (int k = 0; k < 20; k++) begin
      i_mispred = (k == 2 || k == 7 || k == 12);
      i_ctrl    = (k >= 5 && k < 11);
      tick();
    end
    i_mispred = 0; i_ctrl = 0; i_stop = 1;
    tick();
    i_stop = 0;
    check("free_state", 64'(o_state), 64'd2);
    read_word(3'd0, d); check("free_cycles", 64'(d), 64'd21);
    read_word(3'd4, d); check("free_mispred", 64'(d), 64'd3);
    read_word(3'd6, d); check("free_flush", 64'(d), 64'd6);
    $display("TXN free_run done");

    // Clear beats start; start in RUN is ignored.
    i_start = 1; tick(); i_start = 0;
    tick(); tick();
    i_clear = 1; i_start = 1;
    tick();
    i_clear = 0; i_start = 0;
    check("prio_state", 64'(o_state), 64'd0);
    for (int s = 0; s < 8; s += 2) begin
      read_word(3'(s), d);
      check("prio_zero", 64'(d), 64'd0);
    end
    i_start = 1; tick(); i_start = 0;
    repeat (4) tick();
    i_start = 1; tick(); i_start = 0;
    check("run_start_ignored", 64'(o_state), 64'd1);
    tick();
    i_stop = 1; tick(); i_stop = 0;
    read_word(3'd0, d); check("run_start_cycles", 64'(d), 64'd7);
    $display("TXN priority done");

    // Saturation of the 8-bit cycle counter inside a 300-cycle window.
    i_win_len = 300; i_start = 1;
    tick();
    i_start = 0;
    n = 0; ovf_first = 0;
    while (o_state != 2'b10 && n < 320) begin
      tick();
      n++;
      if (o_overflow && ovf_first == 0) ovf_first = n;
    end
    check("sat_window", 64'(n), 64'd300);
    check("sat_ovf_first", 64'(ovf_first), 64'd256);
    check("sat_ovf", 64'(o_overflow), 64'd1);
    read_word(3'd0, d); check("sat_cycles", 64'(d), 64'd255);
    i_win_len = 0; i_start = 1; tick(); i_start = 0;
    check("sat_ovf_cleared", 64'(o_overflow), 64'd0);
    i_stop = 1; tick(); i_stop = 0;
    $display("TXN saturation ovf_first=%0d", ovf_first);

`ifdef PERF_PC_FILTER_EN
    pcs[0] = 32'hFC; pcs[1] = 32'h100; pcs[2] = 32'h104; pcs[3] = 32'h10C; pcs[4] = 32'h110;
    i_start = 1; tick(); i_start = 0;
    for (int k = 0; k < 5; k++) begin
      i_insn_vld = 1; i_pc = pcs[k];
      tick();
    end
    i_insn_vld = 0; i_stop = 1; tick(); i_stop = 0;
    read_word(3'd2, d); check("pc_filter_retired", 64'(d), 64'd3);
    $display("TXN pc_filter done");
`else
    pcs[0] = '0;
    i_pc = pcs[0];
`endif

    // Random traffic against the model.
    for (int c = 0; c < 600; c++) begin
      i_clear    = ($urandom_range(0, 49) == 0);
      i_start    = ($urandom_range(0, 14) == 0);
      i_stop     = ($urandom_range(0, 24) == 0);
      i_insn_vld = 1'($urandom_range(0, 1));
      i_mispred  = ($urandom_range(0, 3) == 0);
      i_ctrl     = ($urandom_range(0, 2) == 0);
      i_rd_sel   = 3'($urandom_range(0, 7));
      i_pc       = 32'($urandom_range(32'hF0, 32'h118));
      if (i_start) i_win_len = ($urandom_range(0, 3) == 0) ? 32'd280 : 32'($urandom_range(0, 40));
      tick();
    end
    i_clear = 1; i_start = 0; i_stop = 0; i_insn_vld = 0; i_mispred = 0; i_ctrl = 0;
    tick();
    i_clear = 0;
    $display("TXN random done");

    // Asynchronous reset in the middle of a run.
    i_win_len = 0; i_rd_sel = 3'd0; i_start = 1; tick(); i_start = 0;
    repeat (5) tick();
    check("pre_reset_rd", 64'(o_rd_data), 64'd4);
    #2;
    i_reset = 1'b0;
    #1;
    check("async_state", 64'(o_state), 64'd0);
    check("async_rd", 64'(o_rd_data), 64'd0);
    check("async_ovf", 64'(o_overflow), 64'd0);
    check("async_busy", 64'(o_busy), 64'd0);
    i_reset = 1'b1;
    tick(); tick();
    $display("TXN async_reset done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
